multicycle_ctrl: RTL and testbench

Sequencing controller for the multi-cycle MIPS core. It takes the opcode and funct fields of the instruction register and steps the shared datapath (pc, im, grf, ext, alu, dm, npc) through FETCH, DECODE, EXEC, MEM and WB states. It drives every write enable and mux select, so each architectural update happens in exactly one cycle. It also holds the PC stable until the instruction's final state and stalls in MEM on a ready handshake from data memory.

---
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control bus between the multi-cycle sequencer and the shared datapath
interface multicycle_ctrl_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        mem_ready;
    logic        PCWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  RegDst;
    logic        ALUSrc;
    logic [1:0]  MemtoReg;
    logic [1:0]  ExtOP;
    logic [1:0]  ALUctr;
    logic [2:0]  nPC_sel;
    logic [2:0]  state;
    logic        instr_done;
    logic [31:0] retired;

    modport master (
        input  opcode, funct, mem_ready,
        output PCWrite, IRWrite, RegWrite, MemWrite, MemRead,
        output RegDst, ALUSrc, MemtoReg, ExtOP, ALUctr, nPC_sel,
        output state, instr_done, retired
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  PCWrite, IRWrite, RegWrite, MemWrite, MemRead,
        input  RegDst, ALUSrc, MemtoReg, ExtOP, ALUctr, nPC_sel,
        input  state, instr_done, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle MIPS core
module multicycle_ctrl (
    input  logic clk,
    input  logic reset,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_OR   = 2'd2;
    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;
    localparam logic [1:0] DST_RT   = 2'd0;
    localparam logic [1:0] DST_RD   = 2'd1;
    localparam logic [1:0] DST_RA   = 2'd2;
    localparam logic [1:0] WD_ALU   = 2'd0;
    localparam logic [1:0] WD_MEM   = 2'd1;
    localparam logic [1:0] WD_EXT   = 2'd2;
    localparam logic [1:0] WD_PC4   = 2'd3;
    localparam logic [2:0] NPC_SEQ  = 3'd0;
    localparam logic [2:0] NPC_BEQ  = 3'd1;
    localparam logic [2:0] NPC_JUMP = 3'd2;
    localparam logic [2:0] NPC_JR   = 3'd3;

    state_e      state_q, state_d;
    logic [31:0] retired_q, retired_d;

    logic is_rtype, is_addu, is_subu, is_jr;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_nop;

    assign is_rtype = (bus.opcode == OP_RTYPE);
    assign is_addu  = is_rtype && (bus.funct == FN_ADDU);
    assign is_subu  = is_rtype && (bus.funct == FN_SUBU);
    assign is_jr    = is_rtype && (bus.funct == FN_JR);
    assign is_ori   = (bus.opcode == OP_ORI);
    assign is_lui   = (bus.opcode == OP_LUI);
    assign is_lw    = (bus.opcode == OP_LW);
    assign is_sw    = (bus.opcode == OP_SW);
    assign is_beq   = (bus.opcode == OP_BEQ);
    assign is_j     = (bus.opcode == OP_J);
    assign is_jal   = (bus.opcode == OP_JAL);
    // Anything unrecognised, including R-type with an unknown funct, retires as PC+4.
    assign is_nop   = !(is_addu || is_subu || is_jr || is_ori || is_lui ||
                        is_lw || is_sw || is_beq || is_j || is_jal);

    // ALU/ext selects set up in EXEC and held through MEM and WB.
    logic [1:0] ex_aluctr;
    logic       ex_alusrc;
    logic [1:0] ex_extop;

    always_comb begin
        ex_aluctr = ALU_ADD;
        ex_alusrc = 1'b0;
        ex_extop  = EXT_ZERO;
        if (is_subu || is_beq) begin
            ex_aluctr = ALU_SUB;
        end else if (is_ori) begin
            ex_aluctr = ALU_OR;
        end
        if (is_lw || is_sw) begin
            ex_alusrc = 1'b1;
            ex_extop  = EXT_SIGN;
        end else if (is_ori) begin
            ex_alusrc = 1'b1;
            ex_extop  = EXT_ZERO;
        end
    end

    logic       pc_write, ir_write, reg_write, mem_write, mem_read, alu_src;
    logic [1:0] reg_dst, mem_to_reg, ext_op, alu_ctr;
    logic [2:0] npc_sel;

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        alu_src    = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = WD_ALU;
        ext_op     = EXT_ZERO;
        alu_ctr    = ALU_ADD;
        npc_sel    = NPC_SEQ;
        case (state_q)
            S_FETCH: begin
                ir_write = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                if (is_j) begin
                    pc_write = 1'b1;
                    npc_sel  = NPC_JUMP;
                    state_d  = S_FETCH;
                end else if (is_jr) begin
                    pc_write = 1'b1;
                    npc_sel  = NPC_JR;
                    state_d  = S_FETCH;
                end else if (is_jal) begin
                    pc_write   = 1'b1;
                    npc_sel    = NPC_JUMP;
                    reg_write  = 1'b1;
                    reg_dst    = DST_RA;
                    mem_to_reg = WD_PC4;
                    state_d    = S_FETCH;
                end else if (is_nop) begin
                    pc_write = 1'b1;
                    npc_sel  = NPC_SEQ;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_ctr = ex_aluctr;
                alu_src = ex_alusrc;
                ext_op  = ex_extop;
                if (is_beq) begin
                    pc_write = 1'b1;
                    npc_sel  = NPC_BEQ;
                    state_d  = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                alu_ctr   = ex_aluctr;
                alu_src   = ex_alusrc;
                ext_op    = ex_extop;
                mem_read  = is_lw;
                mem_write = is_sw;
                if (bus.mem_ready) begin
                    if (is_sw) begin
                        pc_write = 1'b1;
                        npc_sel  = NPC_SEQ;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                alu_ctr   = ex_aluctr;
                alu_src   = ex_alusrc;
                ext_op    = is_lui ? EXT_LUI : ex_extop;
                reg_write = 1'b1;
                pc_write  = 1'b1;
                npc_sel   = NPC_SEQ;
                reg_dst   = (is_addu || is_subu) ? DST_RD : DST_RT;
                if (is_lw) begin
                    mem_to_reg = WD_MEM;
                end else if (is_lui) begin
                    mem_to_reg = WD_EXT;
                end
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // The PC write is the single retirement point, so it also drives the counter.
    assign retired_d = retired_q + 32'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (pc_write) begin
                retired_q <= retired_d;
            end
        end
    end

    assign bus.PCWrite    = pc_write;
    assign bus.IRWrite    = ir_write;
    assign bus.RegWrite   = reg_write;
    assign bus.MemWrite   = mem_write;
    assign bus.MemRead    = mem_read;
    assign bus.RegDst     = reg_dst;
    assign bus.ALUSrc     = alu_src;
    assign bus.MemtoReg   = mem_to_reg;
    assign bus.ExtOP      = ext_op;
    assign bus.ALUctr     = alu_ctr;
    assign bus.nPC_sel    = npc_sel;
    assign bus.state      = state_q;
    assign bus.instr_done = pc_write;
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-instruction observations, filled in by run_instr.
    int          lat, n_rd, n_wr, n_rw, n_pcw;
    logic [15:0] trace;
    logic [1:0]  d_regdst, d_memtoreg, d_extop, d_aluctr;
    logic        d_regwrite, d_alusrc;
    logic [2:0]  d_npc, d_state;

    // Entered while in FETCH; mem_ready rises from cycle index ready_at onward.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int ready_at);
        bus.opcode = op;
        bus.funct  = fn;
        lat = 0; n_rd = 0; n_wr = 0; n_rw = 0; n_pcw = 0; trace = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus.mem_ready = (cyc >= ready_at);
            #1;
            trace = {trace[11:0], 1'b0, bus.state};
            if (bus.MemRead)  n_rd++;
            if (bus.MemWrite) n_wr++;
            if (bus.RegWrite) n_rw++;
            if (bus.PCWrite)  n_pcw++;
            if (bus.instr_done) begin
                lat        = cyc + 1;
                d_regwrite = bus.RegWrite;
                d_regdst   = bus.RegDst;
                d_alusrc   = bus.ALUSrc;
                d_memtoreg = bus.MemtoReg;
                d_extop    = bus.ExtOP;
                d_aluctr   = bus.ALUctr;
                d_npc      = bus.nPC_sel;
                d_state    = bus.state;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1;
        bus.opcode = '0;
        bus.funct = '0;
        bus.mem_ready = 1'b0;
        #3;
        check("rst_state", {29'd0, bus.state}, 32'd0);
        check("rst_irwrite", {31'd0, bus.IRWrite}, 32'd1);
        check("rst_pcwrite", {31'd0, bus.PCWrite}, 32'd0);
        check("rst_retired", bus.retired, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ori $1,$0,0x1234
        run_instr(6'b001101, 6'b000000, 99);
        check("ori_trace", {16'd0, trace}, 32'h0124);
        check("ori_lat", lat, 32'd4);
        check("ori_wb_regwrite", {31'd0, d_regwrite}, 32'd1);
        check("ori_wb_regdst", {30'd0, d_regdst}, 32'd0);
        check("ori_wb_alusrc", {31'd0, d_alusrc}, 32'd1);
        check("ori_wb_extop", {30'd0, d_extop}, 32'd0);
        check("ori_wb_aluctr", {30'd0, d_aluctr}, 32'd2);
        check("ori_back_fetch", {29'd0, bus.state}, 32'd0);
        check("ori_retired", bus.retired, 32'd1);

        // lw with three wait cycles: F D E M M M M WB
        run_instr(6'b100011, 6'b000000, 6);
        check("lw_lat", lat, 32'd8);
        check("lw_memread_cycles", n_rd, 32'd4);
        check("lw_wb_memtoreg", {30'd0, d_memtoreg}, 32'd1);
        check("lw_wb_state", {29'd0, d_state}, 32'd4);
        check("lw_pcwrite_once", n_pcw, 32'd1);

        // sw with mem_ready high throughout (ignored before MEM)
        run_instr(6'b101011, 6'b000000, 0);
        check("sw_lat", lat, 32'd4);
        check("sw_memwrite_cycles", n_wr, 32'd1);
        check("sw_regwrite_cycles", n_rw, 32'd0);
        check("sw_done_state", {29'd0, d_state}, 32'd3);

        run_instr(6'b000100, 6'b000000, 99);
        check("beq_lat", lat, 32'd3);
        check("beq_done_state", {29'd0, d_state}, 32'd2);
        check("beq_aluctr", {30'd0, d_aluctr}, 32'd1);
        check("beq_npc", {29'd0, d_npc}, 32'd1);
        check("beq_regwrite_cycles", n_rw, 32'd0);

        run_instr(6'b000011, 6'b000000, 99);
        check("jal_lat", lat, 32'd2);
        check("jal_regwrite", {31'd0, d_regwrite}, 32'd1);
        check("jal_regdst", {30'd0, d_regdst}, 32'd2);
        check("jal_memtoreg", {30'd0, d_memtoreg}, 32'd3);
        check("jal_npc", {29'd0, d_npc}, 32'd2);

        run_instr(6'b000000, 6'b001000, 99);
        check("jr_lat", lat, 32'd2);
        check("jr_npc", {29'd0, d_npc}, 32'd3);
        check("jr_regwrite_cycles", n_rw, 32'd0);

        run_instr(6'b111111, 6'b000000, 99);
        check("nop_lat", lat, 32'd2);
        check("nop_npc", {29'd0, d_npc}, 32'd0);

        run_instr(6'b000000, 6'b100001, 99);
        check("addu_lat", lat, 32'd4);
        check("addu_regdst", {30'd0, d_regdst}, 32'd1);
        check("addu_aluctr", {30'd0, d_aluctr}, 32'd0);

        run_instr(6'b000000, 6'b100011, 99);
        check("subu_aluctr", {30'd0, d_aluctr}, 32'd1);

        run_instr(6'b001111, 6'b000000, 99);
        check("lui_lat", lat, 32'd4);
        check("lui_memtoreg", {30'd0, d_memtoreg}, 32'd2);
        check("lui_extop", {30'd0, d_extop}, 32'd2);
        check("retired_count", bus.retired, 32'd10);

        // sw stalled in MEM, then reset asserted between clock edges
        bus.opcode = 6'b101011;
        bus.funct = 6'b000000;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("swrst_in_mem", {29'd0, bus.state}, 32'd3);
        check("swrst_memwrite_before", {31'd0, bus.MemWrite}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("swrst_state", {29'd0, bus.state}, 32'd0);
        check("swrst_memwrite", {31'd0, bus.MemWrite}, 32'd0);
        check("swrst_pcwrite", {31'd0, bus.PCWrite}, 32'd0);
        check("swrst_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        check("swrst_retired", bus.retired, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Counter wrap: preload all ones, then retire a j
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        check("wrap_preload", bus.retired, 32'hFFFF_FFFF);
        run_instr(6'b000010, 6'b000000, 99);
        check("j_npc", {29'd0, d_npc}, 32'd2);
        check("wrap_retired", bus.retired, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
